// File: rtl/dual_cam_wr_arbiter_if.sv
// dual_cam_wr_arbiter_if: bundle of the two camera channels and the shared frame-buffer write port.
//   cam0_*/cam1_* : req/addr/data in, gnt/rd/done out (arbiter side)
//   wr_cmd_*      : command channel (valid/addr out, ready in)
//   wr_data*      : data channel (valid/data/last out, ready in)
//   busy/owner    : arbiter status
//   master modport = arbiter, slave modport = cameras + frame buffer
interface dual_cam_wr_arbiter_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 21
);
   logic              cam0_req, cam1_req;
   logic [ADDR_W-1:0] cam0_addr, cam1_addr;
   logic [DATA_W-1:0] cam0_data, cam1_data;
   logic              cam0_gnt, cam1_gnt;
   logic              cam0_rd, cam1_rd;
   logic              cam0_done, cam1_done;
   logic              wr_cmd_valid, wr_cmd_ready;
   logic [ADDR_W-1:0] wr_cmd_addr;
   logic              wr_data_valid, wr_data_ready;
   logic [DATA_W-1:0] wr_data;
   logic              wr_last;
   logic              busy, owner;
   modport master (
      input  cam0_req, cam1_req, cam0_addr, cam1_addr, cam0_data, cam1_data,
      input  wr_cmd_ready, wr_data_ready,
      output cam0_gnt, cam1_gnt, cam0_rd, cam1_rd, cam0_done, cam1_done,
      output wr_cmd_valid, wr_cmd_addr, wr_data_valid, wr_data, wr_last,
      output busy, owner
   );
   modport slave (
      output cam0_req, cam1_req, cam0_addr, cam1_addr, cam0_data, cam1_data,
      output wr_cmd_ready, wr_data_ready,
      input  cam0_gnt, cam1_gnt, cam0_rd, cam1_rd, cam0_done, cam1_done,
      input  wr_cmd_valid, wr_cmd_addr, wr_data_valid, wr_data, wr_last,
      input  busy, owner
   );
endinterface

// File: rtl/dual_cam_wr_arbiter.sv
// dual_cam_wr_arbiter: shares one frame-buffer write port between two camera line buffers, one fixed-length burst at a time.
//   clk, reset : clock, synchronous active-high reset
//   bus        : dual_cam_wr_arbiter_if.master (camera req/addr/data in, gnt/rd/done out; write cmd/data port; busy/owner)
//   Build option DUAL_CAM_ARB_FIXED_PRIO_EN: cam0 always wins contention instead of round-robin.
module dual_cam_wr_arbiter #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 21,
   parameter int BURST_LEN = 64
) (
   input logic                  clk,
   input logic                  reset,
   dual_cam_wr_arbiter_if.master bus
);
   localparam int CW = $clog2(BURST_LEN);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);
   typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_owner_q, last_owner_d;
   logic              gnt_q, gnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              sel;
   logic              beat;
   // sel is the channel to grant when at least one request is present
   always_comb begin
`ifdef DUAL_CAM_ARB_FIXED_PRIO_EN
      sel = ~bus.cam0_req;
`else
      sel = (bus.cam0_req & bus.cam1_req) ? ~last_owner_q : bus.cam1_req;
`endif
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         gnt_q        <= 1'b0;
         addr_q       <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         gnt_q        <= gnt_d;
         addr_q       <= addr_d;
         cnt_q        <= cnt_d;
      end
   end
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      gnt_d        = 1'b0;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      unique case (state_q)
         IDLE: if (bus.cam0_req | bus.cam1_req) begin
            state_d = CMD;
            owner_d = sel;
            addr_d  = sel ? bus.cam1_addr : bus.cam0_addr;
            gnt_d   = 1'b1;
         end
         CMD: if (bus.wr_cmd_ready) begin
            state_d = DATA;
            cnt_d   = '0;
         end
         DATA: if (bus.wr_data_ready) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == LAST_BEAT) ? DONE : DATA;
         end
         DONE: begin
            last_owner_d = owner_q;
            state_d      = IDLE;
         end
      endcase
   end
   always_comb begin
      bus.wr_cmd_valid  = state_q == CMD;
      bus.wr_cmd_addr   = addr_q;
      bus.wr_data_valid = state_q == DATA;
      // data is forced to zero outside DATA so an idle port shows no stale pixels
      bus.wr_data       = bus.wr_data_valid ? (owner_q ? bus.cam1_data : bus.cam0_data) : '0;
      bus.wr_last       = bus.wr_data_valid & (cnt_q == LAST_BEAT);
      beat              = bus.wr_data_valid & bus.wr_data_ready;
      bus.cam0_rd       = beat & ~owner_q;
      bus.cam1_rd       = beat & owner_q;
      bus.cam0_gnt      = gnt_q & ~owner_q;
      bus.cam1_gnt      = gnt_q & owner_q;
      bus.cam0_done     = (state_q == DONE) & ~owner_q;
      bus.cam1_done     = (state_q == DONE) & owner_q;
      bus.busy          = state_q != IDLE;
      bus.owner         = owner_q;
   end
endmodule
